// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: fetch FSM states, opcode/NOP constants and
// the B-type immediate decoder used by the fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

  // Sign-extended branch offset: {imm[12], imm[11], imm[10:5], imm[4:1], 0}.
  function automatic logic [31:0] b_imm(input logic [31:0] instr);
    b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/if_predecode.sv
// Combinational pre-decode for the static backward-taken predictor: flags a
// backward B-type branch and computes its target from the fetch PC.
module if_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_is_bwd_branch,
  output logic [31:0] o_target
);

  assign o_is_bwd_branch = (i_instr[6:0] == OPC_BRANCH) && i_instr[31];
  assign o_target        = i_pc + b_imm(i_instr);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem request/wait handling, stall hold slot and
// redirect drain. Define IF_BTFN_PREDICT_EN to enable the backward-taken predictor.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         mem_stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  instr_o,
  output logic         valid_o,
  output logic         pred_taken_o,
  output fetch_state_e dbg_state_o
);

  // Handshake: imem_req_o/imem_addr_o stay stable from the first request cycle
  // until the cycle imem_ack_i is high; that cycle completes the request and
  // imem_rdata_i is consumed (or discarded during a drain) at the same edge.

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic [31:0]  r_pend_instr;
  logic         r_pend_pred;
  logic [31:0]  r_pc_o;
  logic [31:0]  r_instr_o;
  logic         r_valid_o;
  logic         r_pred_o;

  logic         w_adv;
  logic         w_slot_free;
  logic         w_pred;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;

  assign w_adv       = !stall_i && !mem_stall_i;
  assign w_slot_free = !r_valid_o || w_adv;
  assign w_pc_plus4  = r_pc + 32'd4;

`ifdef IF_BTFN_PREDICT_EN
  logic [31:0] w_target;

  if_predecode u_predecode (
    .i_pc            (r_pc),
    .i_instr         (imem_rdata_i),
    .o_is_bwd_branch (w_pred),
    .o_target        (w_target)
  );

  assign w_next_pc = w_pred ? w_target : w_pc_plus4;
`else
  assign w_pred    = 1'b0;
  assign w_next_pc = w_pc_plus4;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= FS_IDLE;
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_instr <= '0;
      r_pend_pred  <= 1'b0;
      r_pc_o       <= '0;
      r_instr_o    <= '0;
      r_valid_o    <= 1'b0;
      r_pred_o     <= 1'b0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (start_i) r_state <= FS_FETCH;
        end

        FS_FETCH: begin
          if (redirect_i) begin
            // An un-acked request is still in flight and must be drained.
            r_pc        <= redirect_pc_i;
            r_valid_o   <= 1'b0;
            r_pend_pred <= 1'b0;
            r_state     <= imem_ack_i ? FS_FETCH : FS_DRAIN;
          end else if (imem_ack_i) begin
            r_pc <= w_next_pc;
            if (w_slot_free) begin
              r_pc_o    <= r_pc;
              r_instr_o <= imem_rdata_i;
              r_valid_o <= 1'b1;
              r_pred_o  <= w_pred;
            end else begin
              r_pend_pc    <= r_pc;
              r_pend_instr <= imem_rdata_i;
              r_pend_pred  <= w_pred;
              r_state      <= FS_HOLD;
            end
          end else if (w_adv && r_valid_o) begin
            r_valid_o <= 1'b0;
          end
        end

        FS_HOLD: begin
          if (redirect_i) begin
            r_pc        <= redirect_pc_i;
            r_valid_o   <= 1'b0;
            r_pend_pred <= 1'b0;
            r_state     <= FS_FETCH;
          end else if (w_adv) begin
            r_pc_o    <= r_pend_pc;
            r_instr_o <= r_pend_instr;
            r_valid_o <= 1'b1;
            r_pred_o  <= r_pend_pred;
            r_state   <= FS_FETCH;
          end
        end

        FS_DRAIN: begin
          if (redirect_i) begin
            r_pc      <= redirect_pc_i;
            r_valid_o <= 1'b0;
          end
          if (imem_ack_i) r_state <= FS_FETCH;
        end

        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign imem_req_o   = (r_state == FS_FETCH);
  assign imem_addr_o  = r_pc;
  assign pc_o         = r_pc_o;
  assign instr_o      = r_instr_o;
  assign valid_o      = r_valid_o;
  assign pred_taken_o = r_pred_o;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (RESET_PC=0x100): streaming, wait states,
// stall/HOLD, redirect drain, predictor, PC wrap and reset mid-HOLD.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         stall_i;
  logic         mem_stall_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_ack_i;
  logic [31:0]  imem_rdata_i;
  logic [31:0]  pc_o;
  logic [31:0]  instr_o;
  logic         valid_o;
  logic         pred_taken_o;
  fetch_state_e dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .mem_stall_i   (mem_stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .pred_taken_o  (pred_taken_o),
    .dbg_state_o   (dbg_state_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ins);
    check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"}, pc_o, pc);
      check({tag, "_instr"}, instr_o, ins);
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr,
                           input fetch_state_e st);
    check({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
    check({tag, "_addr"}, imem_addr_o, addr);
    check({tag, "_state"}, {30'd0, dbg_state_o}, {30'd0, st});
  endtask

  task automatic ack(input logic a, input logic [31:0] d);
    imem_ack_i   = a;
    imem_rdata_i = d;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; mem_stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; imem_ack_i = 1'b0; imem_rdata_i = '0;
    tick();
    check_req("rst", 1'b0, 32'h100, FS_IDLE);
    check("rst_pc_o", pc_o, 32'h0);
    check("rst_instr_o", instr_o, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_pred", {31'd0, pred_taken_o}, 32'd0);

    // Start: request to 0x100 after the first edge.
    rst_i = 1'b0; start_i = 1'b1;
    tick();
    check_req("start", 1'b1, 32'h100, FS_FETCH);

    // Zero-wait streaming 0x100, 0x104, 0x108.
    ack(1'b1, 32'hA000_0100); tick();
    check_out("s100", 1'b1, 32'h100, 32'hA000_0100);
    check_req("s100", 1'b1, 32'h104, FS_FETCH);
    ack(1'b1, 32'hA000_0104); tick();
    check_out("s104", 1'b1, 32'h104, 32'hA000_0104);
    check("s104_addr", imem_addr_o, 32'h108);
    ack(1'b1, 32'hA000_0108); tick();
    check_out("s108", 1'b1, 32'h108, 32'hA000_0108);
    check("s108_addr", imem_addr_o, 32'h10C);

    // Two wait cycles on 0x10C -> two bubbles, address held.
    ack(1'b0, 32'h0); tick();
    check_out("w1", 1'b0, 32'h0, 32'h0);
    check("w1_addr", imem_addr_o, 32'h10C);
    tick();
    check_out("w2", 1'b0, 32'h0, 32'h0);
    check("w2_addr", imem_addr_o, 32'h10C);
    ack(1'b1, 32'hA000_010C); tick();
    check_out("w3", 1'b1, 32'h10C, 32'hA000_010C);
    check("w3_addr", imem_addr_o, 32'h110);

    // Stall for 3 cycles while 0x110 is acked -> HOLD, output frozen.
    stall_i = 1'b1; ack(1'b1, 32'hA000_0110); tick();
    check_out("h1", 1'b1, 32'h10C, 32'hA000_010C);
    check_req("h1", 1'b0, 32'h114, FS_HOLD);
    ack(1'b0, 32'h0); mem_stall_i = 1'b1; stall_i = 1'b0; tick();
    check_out("h2", 1'b1, 32'h10C, 32'hA000_010C);
    mem_stall_i = 1'b0; stall_i = 1'b1; tick();
    check_out("h3", 1'b1, 32'h10C, 32'hA000_010C);
    stall_i = 1'b0; tick();
    check_out("h4", 1'b1, 32'h110, 32'hA000_0110);
    check_req("h4", 1'b1, 32'h114, FS_FETCH);

    // Bubble, then redirect to 0x200 while 0x114 is outstanding -> DRAIN.
    tick();
    check_out("b", 1'b0, 32'h0, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'h200; stall_i = 1'b1; tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    check_req("rd", 1'b0, 32'h200, FS_DRAIN);
    check_out("rd", 1'b0, 32'h0, 32'h0);
    ack(1'b1, 32'hDEAD_BEEF); tick();
    check_req("dr", 1'b1, 32'h200, FS_FETCH);
    check_out("dr", 1'b0, 32'h0, 32'h0);
    ack(1'b1, 32'hA000_0200); tick();
    check_out("r200", 1'b1, 32'h200, 32'hA000_0200);
    check("r200_pred", {31'd0, pred_taken_o}, 32'd0);

    // Backward branch (beq, offset -4) fetched at 0x204.
    ack(1'b1, 32'hFE00_0EE3); tick();
    check_out("br", 1'b1, 32'h204, 32'hFE00_0EE3);
`ifdef IF_BTFN_PREDICT_EN
    check("br_addr", imem_addr_o, 32'h200);
    check("br_pred", {31'd0, pred_taken_o}, 32'd1);
`else
    check("br_addr", imem_addr_o, 32'h208);
    check("br_pred", {31'd0, pred_taken_o}, 32'd0);
`endif

    // Redirect with ack in the same cycle: data dropped, fetch at new PC.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; ack(1'b1, 32'h1234_5678); tick();
    redirect_i = 1'b0;
    check_req("rda", 1'b1, 32'hFFFF_FFFC, FS_FETCH);
    check_out("rda", 1'b0, 32'h0, 32'h0);
    ack(1'b1, INSTR_NOP); tick();
    check_out("wrap", 1'b1, 32'hFFFF_FFFC, INSTR_NOP);
    check("wrap_addr", imem_addr_o, 32'h0);

    // Enter HOLD, then reset asynchronously mid-cycle.
    stall_i = 1'b1; ack(1'b1, 32'hA000_0000); tick();
    check_req("hr", 1'b0, 32'h4, FS_HOLD);
    #2 rst_i = 1'b1;
    #1;
    check_req("arst", 1'b0, 32'h100, FS_IDLE);
    check("arst_pc_o", pc_o, 32'h0);
    check("arst_instr_o", instr_o, 32'h0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; ack(1'b1, 32'hBAD0_BAD0); tick();
    check_req("stray", 1'b0, 32'h100, FS_IDLE);
    check("stray_valid", {31'd0, valid_o}, 32'd0);
    start_i = 1'b1; ack(1'b0, 32'h0); tick();
    check_req("restart", 1'b1, 32'h100, FS_FETCH);
    ack(1'b1, 32'hA000_0100); tick();
    check_out("restart", 1'b1, 32'h100, 32'hA000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage RV32 pipeline. It owns the program counter, issues instruction-memory requests, absorbs memory wait states, and presents a registered {pc, instruction, valid} triple to the IF/ID pipeline register. It handles pipeline stalls, memory stalls and branch/flush redirects, including a redirect that arrives while a fetch is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- clk  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  CPU start level; sampled only in IDLE.
- stall_i  in  1  hazard-unit stall (IF_stall); output must hold.
- mem_stall_i  in  1  data-memory stall; treated exactly like stall_i.
- redirect_i  in  1  flush/redirect from ID/EX (taken branch, mispredict).
- redirect_pc_i  in  32  new fetch address; valid with redirect_i.
- imem_req_o  out  1  instruction-memory request.
- imem_addr_o  out  32  request address; equals internal pc.
- imem_ack_i  in  1  single-cycle acknowledge; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction word.
- pc_o  out  32  PC of instr_o, to IF/ID PC_i.
- instr_o  out  32  fetched instruction, to IF/ID instruction_i.
- valid_o  out  1  pc_o/instr_o hold a live instruction.
- pred_taken_o  out  1  instr_o was fetched with predicted-taken next PC.

## Operation
- Advance condition: adv = !stall_i && !mem_stall_i. Output slot free = !valid_o || adv.
- Four states: IDLE, FETCH, HOLD, DRAIN.
- IDLE: imem_req_o=0. start_i=1 -> FETCH next cycle.
- FETCH: imem_req_o=1, imem_addr_o=pc; address is held stable until ack.
  - ack && slot free: load output {pc, rdata, valid=1}, pc <= next_pc, stay in FETCH.
  - ack && slot not free: store {pc, rdata} in a one-entry pending register, pc <= next_pc, go to HOLD.
  - no ack && adv && valid_o: valid_o <= 0 (bubble).
- HOLD: imem_req_o=0. When adv, move pending into the output and go to FETCH.
- next_pc = pc + 4, modulo 2^32; wrap at 32'hFFFF_FFFC to 0 is silent.
- redirect_i has priority over everything else in any non-IDLE state:
  - pc <= redirect_pc_i; valid_o <= 0; pending is discarded.
  - FETCH without ack: go to DRAIN, because the outstanding request must complete.
  - FETCH with ack in the same cycle: rdata is discarded; stay in FETCH at the new pc.
  - HOLD: go to FETCH.
  - DRAIN: pc is updated; stay in DRAIN.
- DRAIN: imem_req_o=0. The next ack is discarded; then go to FETCH. Memory guarantees an ack for every accepted request.
- redirect_i is ignored in IDLE.
- stall_i and redirect_i together: redirect wins.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC.
  - pc_o=0, instr_o=0, valid_o=0, pred_taken_o=0, pending cleared.
- start_i high at edge N: imem_req_o high after edge N.
- Zero-wait memory (ack in the request cycle): valid_o with the matching instruction one cycle after the request; sustained throughput is one instruction per cycle.
- k wait cycles cost k bubble cycles (valid_o=0).
- Redirect at edge N with no fetch outstanding: request to redirect_pc_i issued after edge N; valid_o=0 for that cycle.
- All outputs are registered except imem_req_o and imem_addr_o, which are decoded from state/pc registers only; there are no combinational input-to-output paths.
- rst_i mid-fetch: immediate return to reset values. Any later stray ack is ignored because the block is in IDLE.

## Configuration
- IF_BTFN_PREDICT_EN defined: static backward-taken predictor.
  - Applies when rdata is B-type (opcode 7'b1100011) and rdata[31]=1.
  - next_pc = pc + sext({rdata[31], rdata[7], rdata[30:25], rdata[11:8], 1'b0}).
  - pred_taken_o=1 is loaded with that instruction, including via the pending path.
  - The later stage corrects mispredicts through redirect_i.
- IF_BTFN_PREDICT_EN undefined: next_pc is always pc+4 and pred_taken_o is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - the fetch state enum (IDLE/FETCH/HOLD/DRAIN);
  - OPC_BRANCH = 7'b1100011;
  - INSTR_NOP = 32'h0000_0013;
  - the B-immediate extraction function.
- One sub-module, if_predecode: combinational {is_bwd_branch, target}. It is instantiated only under IF_BTFN_PREDICT_EN.

## Test plan
- Reset with RESET_PC=32'h100, start_i=1, zero-wait memory -> imem_addr_o sequence 100, 104, 108; pc_o/instr_o follow one cycle later; valid_o continuously 1.
- 2-cycle memory wait on 0x104 -> two valid_o=0 bubbles; pc_o=0x104 is presented exactly once; no address skipped.
- stall_i held 3 cycles while ack for 0x108 arrives -> HOLD; pc_o stays 0x104; 0x108 appears the cycle after stall_i drops; no duplicate or lost instruction.
- redirect_i to 0x200 during an outstanding un-acked fetch of 0x10C -> DRAIN; the ack data is discarded; the next request address is 0x200; valid_o=0 until 0x200 returns.
- With IF_BTFN_PREDICT_EN, instruction 32'hFE000EE3 (beq, offset -4) at 0x110 -> next request 0x10C and pred_taken_o=1 with it. Without the macro -> next request 0x114 and pred_taken_o=0.
- rst_i asserted mid-HOLD -> all outputs return to reset values immediately; the first request after restart goes to RESET_PC.
